// File: rtl/display_scan_scheduler.sv
// Round-robin anode scheduler for multiplexed seven-segment digits sharing one segment bus.
// Each enabled digit is driven for DWELL_CYCLES, separated by BLANK_CYCLES with every anode off.
module display_scan_scheduler #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned DWELL_CYCLES = 2400,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS-1:0]         en_mask,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          load,
  output logic                          scanning
);

  localparam int unsigned IW      = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_BLANK,
    S_ON,
    S_IDLE
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         nxt_q;
  logic [IW-1:0]         idx_q;
  logic [NUM_DIGITS-1:0] anode_n_q;
  logic                  load_q;
  logic                  scanning_q;

  logic                  found;
  logic [IW-1:0]         pick;

  function automatic logic [NUM_DIGITS-1:0] onehot_n(input logic [IW-1:0] k);
    return ~(NUM_DIGITS'(1) << k);
  endfunction

  // Cyclic search of en_mask starting at nxt_q; the first enabled digit wins.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      j = 32'(nxt_q) + i;
      if (j >= NUM_DIGITS) j = j - NUM_DIGITS;
      if (!found && en_mask[IW'(j)]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BLANK;
      cnt_q      <= '0;
      nxt_q      <= '0;
      idx_q      <= '0;
      anode_n_q  <= '1;
      load_q     <= 1'b0;
      scanning_q <= 1'b1;
    end else begin
      load_q <= 1'b0;
      unique case (state_q)
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_q <= '0;
            if (found) begin
              state_q   <= S_ON;
              idx_q     <= pick;
              nxt_q     <= (pick == LAST_DIGIT) ? '0 : IW'(pick + 1'b1);
              anode_n_q <= onehot_n(pick);
              load_q    <= 1'b1;
            end else begin
              state_q    <= S_IDLE;
              scanning_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ON: begin
          // A disabled digit and the natural dwell end both fall back to BLANK.
          if (!en_mask[idx_q] || (cnt_q == DWELL_LAST)) begin
            state_q   <= S_BLANK;
            cnt_q     <= '0;
            anode_n_q <= '1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (|en_mask) begin
            state_q    <= S_BLANK;
            cnt_q      <= '0;
            scanning_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_BLANK;
          cnt_q      <= '0;
          anode_n_q  <= '1;
          scanning_q <= 1'b1;
        end
      endcase
    end
  end

  assign anode_n   = anode_n_q;
  assign digit_idx = idx_q;
  assign load      = load_q;
  assign scanning  = scanning_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: directed vector tables, reset/corner sequences,
// a 4-digit instance, and random en_mask traffic against a cycle-level schedule model.
module tb_display_scan_scheduler;

  localparam int TN  = 2;
  localparam int TDW = 4;
  localparam int TBL = 2;

  logic       clk;
  logic       reset;
  logic [1:0] en_mask;
  logic [1:0] anode_n;
  logic       digit_idx;
  logic       load;
  logic       scanning;

  logic [3:0] en2;
  logic [3:0] anode2_n;
  logic [1:0] digit2_idx;
  logic       load2;
  logic       scanning2;

  int n_cmp;
  int n_bad;

  display_scan_scheduler #(
    .NUM_DIGITS  (TN),
    .DWELL_CYCLES(TDW),
    .BLANK_CYCLES(TBL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en_mask  (en_mask),
    .anode_n  (anode_n),
    .digit_idx(digit_idx),
    .load     (load),
    .scanning (scanning)
  );

  display_scan_scheduler #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(3),
    .BLANK_CYCLES(1)
  ) dut4 (
    .clk      (clk),
    .reset    (reset),
    .en_mask  (en2),
    .anode_n  (anode2_n),
    .digit_idx(digit2_idx),
    .load     (load2),
    .scanning (scanning2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Schedule model: which digit is lit (-1 = dark), cycles remaining in the current phase.
  int m_lit, m_rem, m_ptr, m_last;
  bit m_idle, m_load;

  task automatic model_reset();
    m_lit = -1; m_rem = TBL; m_ptr = 0; m_last = 0; m_idle = 0; m_load = 0;
  endtask

  task automatic model_step(input logic [1:0] m);
    bit hit;
    m_load = 0;
    if (m_idle) begin
      if (m != 0) begin
        m_idle = 0;
        m_rem  = TBL;
      end
    end else if (m_lit >= 0) begin
      if (m[m_lit] == 1'b0 || m_rem == 1) begin
        m_lit = -1;
        m_rem = TBL;
      end else begin
        m_rem--;
      end
    end else if (m_rem == 1) begin
      hit = 0;
      for (int i = 0; i < TN; i++) begin
        int d;
        d = (m_ptr + i) % TN;
        if (!hit && m[d]) begin
          hit = 1; m_lit = d; m_last = d; m_ptr = (d + 1) % TN;
          m_rem = TDW; m_load = 1;
        end
      end
      if (!hit) m_idle = 1;
    end else begin
      m_rem--;
    end
  endtask

  task automatic check_model(input string tag);
    logic [1:0] ea;
    ea = (m_lit < 0) ? 2'b11 : ~(2'b01 << m_lit);
    chk({tag, ".anode_n"},   32'(anode_n),   32'(ea));
    chk({tag, ".digit_idx"}, 32'(digit_idx), 32'(m_last));
    chk({tag, ".load"},      32'(load),      32'(m_load));
    chk({tag, ".scanning"},  32'(scanning),  32'(!m_idle));
  endtask

  task automatic cycle(input logic [1:0] m, input string tag);
    en_mask = m;
    @(posedge clk);
    model_step(m);
    #1;
    check_model(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".anode_n"},   32'(anode_n),   32'h3);
    chk({tag, ".digit_idx"}, 32'(digit_idx), 32'h0);
    chk({tag, ".load"},      32'(load),      32'h0);
    chk({tag, ".scanning"},  32'(scanning),  32'h1);
    chk({tag, ".anode4_n"},  32'(anode2_n),  32'hf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] mask;
    logic [1:0] anode;
    logic       idx;
    logic       ld;
    logic       scan;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input logic [1:0] m, input logic [1:0] a,
                              input logic i, input logic l, input logic s);
    vec_t v;
    v.rst = r; v.mask = m; v.anode = a; v.idx = i; v.ld = l; v.scan = s;
    tbl.push_back(v);
  endfunction

  task automatic run_table(input int first, input int last, input bit allow_rst);
    for (int k = first; k <= last; k++) begin
      if (tbl[k].rst && allow_rst) do_reset();
      en_mask = tbl[k].mask;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.anode_n", k),   32'(anode_n),   32'(tbl[k].anode));
      chk($sformatf("vec%0d.digit_idx", k), 32'(digit_idx), 32'(tbl[k].idx));
      chk($sformatf("vec%0d.load", k),      32'(load),      32'(tbl[k].ld));
      chk($sformatf("vec%0d.scanning", k),  32'(scanning),  32'(tbl[k].scan));
    end
  endtask

  initial begin
    logic [1:0] cur;
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    en_mask = 2'b00;
    en2     = 4'b1010;
    model_reset();

    // two digits enabled: 0..11
    add(1, 2'b11, 2'b11, 0, 0, 1);
    add(0, 2'b11, 2'b10, 0, 1, 1);
    add(0, 2'b11, 2'b10, 0, 0, 1);
    add(0, 2'b11, 2'b10, 0, 0, 1);
    add(0, 2'b11, 2'b10, 0, 0, 1);
    add(0, 2'b11, 2'b11, 0, 0, 1);
    add(0, 2'b11, 2'b11, 0, 0, 1);
    add(0, 2'b11, 2'b01, 1, 1, 1);
    add(0, 2'b11, 2'b01, 1, 0, 1);
    add(0, 2'b11, 2'b01, 1, 0, 1);
    add(0, 2'b11, 2'b01, 1, 0, 1);
    add(0, 2'b11, 2'b11, 1, 0, 1);
    // only digit 1 enabled: 12..20
    add(1, 2'b10, 2'b11, 0, 0, 1);
    add(0, 2'b10, 2'b01, 1, 1, 1);
    add(0, 2'b10, 2'b01, 1, 0, 1);
    add(0, 2'b10, 2'b01, 1, 0, 1);
    add(0, 2'b10, 2'b01, 1, 0, 1);
    add(0, 2'b10, 2'b11, 1, 0, 1);
    add(0, 2'b10, 2'b11, 1, 0, 1);
    add(0, 2'b10, 2'b01, 1, 1, 1);
    add(0, 2'b10, 2'b01, 1, 0, 1);
    // idle then wake: 21..27
    add(1, 2'b00, 2'b11, 0, 0, 1);
    add(0, 2'b00, 2'b11, 0, 0, 0);
    add(0, 2'b00, 2'b11, 0, 0, 0);
    add(0, 2'b01, 2'b11, 0, 0, 1);
    add(0, 2'b01, 2'b11, 0, 0, 1);
    add(0, 2'b01, 2'b10, 0, 1, 1);
    add(0, 2'b01, 2'b10, 0, 0, 1);
    // truncated dwell: 28..37
    add(1, 2'b11, 2'b11, 0, 0, 1);
    add(0, 2'b11, 2'b10, 0, 1, 1);
    add(0, 2'b11, 2'b10, 0, 0, 1);
    add(0, 2'b10, 2'b11, 0, 0, 1);
    add(0, 2'b10, 2'b11, 0, 0, 1);
    add(0, 2'b10, 2'b01, 1, 1, 1);
    add(0, 2'b10, 2'b01, 1, 0, 1);
    add(0, 2'b10, 2'b01, 1, 0, 1);
    add(0, 2'b10, 2'b01, 1, 0, 1);
    add(0, 2'b10, 2'b11, 1, 0, 1);

    run_table(0, tbl.size() - 1, 1'b1);

    // Asynchronous reset while digit 1 is lit, then a clean restart.
    do_reset();
    for (int k = 0; k < 9; k++) cycle(2'b11, "pre_rst");
    chk("mid.anode_lit", 32'(anode_n), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async");
    @(posedge clk);
    #1;
    chk_reset_vals("held");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run_table(0, 11, 1'b0);

    // Four-digit instance, en_mask=1010: digits 1,3 alternate, 3 lit cycles each, 1 blank.
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      int p;
      logic [3:0] ea;
      logic [1:0] ei;
      @(posedge clk);
      #1;
      p  = (k - 1) % 8;
      ea = (p < 3) ? 4'b1101 : (p == 3 || p == 7) ? 4'b1111 : 4'b0111;
      ei = (p < 4) ? 2'd1 : 2'd3;
      chk($sformatf("d4_%0d.anode_n", k),   32'(anode2_n),   32'(ea));
      chk($sformatf("d4_%0d.digit_idx", k), 32'(digit2_idx), 32'(ei));
      chk($sformatf("d4_%0d.load", k),      32'(load2),      32'(p == 0 || p == 4));
    end

    // Random en_mask traffic against the model.
    do_reset();
    cur = 2'b11;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) cur = 2'($urandom_range(0, 3));
      cycle(cur, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
